// File: rtl/dual_port_ram_be.sv
// True dual-port synchronous RAM with byte-lane write enables, selectable read-during-write,
// optional output register stage and fixed-priority same-address write-collision resolution.
module dual_port_ram_be #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 10,
  parameter int unsigned BW       = 8,
  parameter int unsigned RDW_MODE = 0,
  parameter int unsigned OUT_REG  = 0,
  parameter int unsigned PRI_B    = 0,
  localparam int unsigned NB      = DW / BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_a,
  input  logic          we_a,
  input  logic [NB-1:0] be_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  output logic [DW-1:0] dout_a,
  output logic          dvld_a,
  input  logic          en_b,
  input  logic          we_b,
  input  logic [NB-1:0] be_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] din_b,
  output logic [DW-1:0] dout_b,
  output logic          dvld_b,
  output logic          collide
);

  localparam int unsigned DP = 2 ** AW;

  logic [DW-1:0] mem [DP];

  // Index 0 is port A, index 1 is port B.
  logic [1:0]           en, we, wr;
  logic [1:0][NB-1:0]   be, lane_wr;
  logic [1:0][AW-1:0]   addr;
  logic [1:0][DW-1:0]   din, rd_word;
  logic [NB-1:0]        overlap;

  logic [1:0]           s1_vld;
  logic [1:0][DW-1:0]   s1_dout;
  logic                 collide_q;

  assign en   = {en_b, en_a};
  assign we   = {we_b, we_a};
  assign be   = {be_b, be_a};
  assign addr = {addr_b, addr_a};
  assign din  = {din_b, din_a};

  assign wr      = en & we & {2{~rst}};
  assign overlap = (wr[0] && wr[1] && (addr[0] == addr[1])) ? (be[0] & be[1]) : '0;

  // The losing port is masked off the shared lanes so each lane has at most one writer.
  always_comb begin
    lane_wr[0] = wr[0] ? be[0] : '0;
    lane_wr[1] = wr[1] ? be[1] : '0;
    if (PRI_B != 0) begin
      lane_wr[0] = lane_wr[0] & ~overlap;
    end else begin
      lane_wr[1] = lane_wr[1] & ~overlap;
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < NB; k++) begin
        if (lane_wr[p][k]) begin
          mem[addr[p]][k*BW +: BW] <= din[p][k*BW +: BW];
        end
      end
    end
  end

  // Write-through returns this port's own merge, regardless of collision outcome.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = mem[addr[p]];
      if (RDW_MODE != 0 && we[p]) begin
        for (int k = 0; k < NB; k++) begin
          if (be[p][k]) begin
            rd_word[p][k*BW +: BW] = din[p][k*BW +: BW];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= '0;
      s1_dout   <= '0;
      collide_q <= 1'b0;
    end else begin
      s1_vld    <= en;
      collide_q <= |overlap;
      for (int p = 0; p < 2; p++) begin
        if (en[p]) begin
          s1_dout[p] <= rd_word[p];
        end
      end
    end
  end

  assign collide = collide_q;

  if (OUT_REG != 0) begin : g_out_reg
    logic [1:0]         s2_vld;
    logic [1:0][DW-1:0] s2_dout;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_vld  <= '0;
        s2_dout <= '0;
      end else begin
        s2_vld <= s1_vld;
        for (int p = 0; p < 2; p++) begin
          if (s1_vld[p]) begin
            s2_dout[p] <= s1_dout[p];
          end
        end
      end
    end

    assign dout_a = s2_dout[0];
    assign dout_b = s2_dout[1];
    assign dvld_a = s2_vld[0];
    assign dvld_b = s2_vld[1];
  end else begin : g_no_out_reg
    assign dout_a = s1_dout[0];
    assign dout_b = s1_dout[1];
    assign dvld_a = s1_vld[0];
    assign dvld_b = s1_vld[1];
  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench: three RAM instances share stimulus (read-first/A-wins, write-through/B-wins,
// output-registered) and are checked against hand-computed vectors and sequences.
module tb_dual_port_ram_be;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic        clk, rst;
  logic        en_a, we_a, en_b, we_b;
  logic [3:0]  be_a, be_b;
  logic [9:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b;

  logic [31:0] dout_a [3];
  logic [31:0] dout_b [3];
  logic        dvld_a [3];
  logic        dvld_b [3];
  logic        collide [3];

  int checks   = 0;
  int failures = 0;

  dual_port_ram_be #(.RDW_MODE(0), .OUT_REG(0), .PRI_B(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a[0]), .dvld_a(dvld_a[0]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b[0]), .dvld_b(dvld_b[0]), .collide(collide[0])
  );

  dual_port_ram_be #(.RDW_MODE(1), .OUT_REG(0), .PRI_B(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a[1]), .dvld_a(dvld_a[1]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b[1]), .dvld_b(dvld_b[1]), .collide(collide[1])
  );

  dual_port_ram_be #(.RDW_MODE(0), .OUT_REG(1), .PRI_B(0)) u_dut2 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a[2]), .dvld_a(dvld_a[2]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b[2]), .dvld_b(dvld_b[2]), .collide(collide[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en_a, we_a;
    logic [3:0]  be_a;
    logic [9:0]  addr_a;
    logic [31:0] din_a;
    logic        en_b, we_b;
    logic [3:0]  be_b;
    logic [9:0]  addr_b;
    logic [31:0] din_b;
    logic        vld_a, vld_b;
    logic [31:0] a0, b0;
    logic        col0;
    logic [31:0] a1, b1;
    logic        col1;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ea, input logic wa, input logic [3:0] ba,
                       input logic [9:0] aa, input logic [31:0] da,
                       input logic eb, input logic wb, input logic [3:0] bb,
                       input logic [9:0] ab, input logic [31:0] db);
    en_a = ea; we_a = wa; be_a = ba; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; be_b = bb; addr_b = ab; din_b = db;
  endtask

  task automatic idle();
    drive(N, N, 4'h0, 10'h000, 32'h0, N, N, 4'h0, 10'h000, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input int d, input string tag);
    chk({tag, " dout_a"}, dout_a[d], 32'h0);
    chk({tag, " dout_b"}, dout_b[d], 32'h0);
    chk({tag, " dvld_a"}, {31'h0, dvld_a[d]}, 32'h0);
    chk({tag, " dvld_b"}, {31'h0, dvld_b[d]}, 32'h0);
    chk({tag, " collide"}, {31'h0, collide[d]}, 32'h0);
  endtask

  initial begin
    //       en we be    addr     din           en we be    addr     din
    //       vld_a vld_b dut0 a / b / col       dut1 a / b / col
    vecs[0]  = '{Y, Y, 4'hF, 10'h005, 32'hDEADBEEF, Y, N, 4'h0, 10'h010, 32'h0,
                 Y, Y, 32'h00000000, 32'h11223344, N, 32'hDEADBEEF, 32'h11223344, N};
    vecs[1]  = '{Y, Y, 4'h5, 10'h010, 32'hAABBCCDD, Y, N, 4'h0, 10'h005, 32'h0,
                 Y, Y, 32'h11223344, 32'hDEADBEEF, N, 32'h11BB33DD, 32'hDEADBEEF, N};
    vecs[2]  = '{Y, N, 4'h0, 10'h010, 32'h0, N, N, 4'h0, 10'h000, 32'h0,
                 Y, N, 32'h11BB33DD, 32'hDEADBEEF, N, 32'h11BB33DD, 32'hDEADBEEF, N};
    vecs[3]  = '{Y, Y, 4'h3, 10'h020, 32'hAAAAAAAA, Y, Y, 4'h6, 10'h020, 32'hBBBBBBBB,
                 Y, Y, 32'h00000000, 32'h00000000, Y, 32'h0000AAAA, 32'h00BBBB00, Y};
    vecs[4]  = '{Y, N, 4'h0, 10'h020, 32'h0, Y, N, 4'h0, 10'h020, 32'h0,
                 Y, Y, 32'h00BBAAAA, 32'h00BBAAAA, N, 32'h00BBBBAA, 32'h00BBBBAA, N};
    vecs[5]  = '{Y, Y, 4'h3, 10'h020, 32'hAAAAAAAA, Y, Y, 4'hC, 10'h020, 32'hBBBBBBBB,
                 Y, Y, 32'h00BBAAAA, 32'h00BBAAAA, N, 32'h00BBAAAA, 32'hBBBBBBAA, N};
    vecs[6]  = '{Y, N, 4'h0, 10'h020, 32'h0, N, N, 4'h0, 10'h000, 32'h0,
                 Y, N, 32'hBBBBAAAA, 32'h00BBAAAA, N, 32'hBBBBAAAA, 32'hBBBBBBAA, N};
    vecs[7]  = '{Y, Y, 4'hF, 10'h030, 32'hCAFEF00D, Y, N, 4'h0, 10'h030, 32'h0,
                 Y, Y, 32'h12345678, 32'h12345678, N, 32'hCAFEF00D, 32'h12345678, N};
    vecs[8]  = '{N, N, 4'h0, 10'h000, 32'h0, Y, N, 4'h0, 10'h030, 32'h0,
                 N, Y, 32'h12345678, 32'hCAFEF00D, N, 32'hCAFEF00D, 32'hCAFEF00D, N};
    vecs[9]  = '{Y, Y, 4'h0, 10'h005, 32'hFFFFFFFF, N, N, 4'h0, 10'h000, 32'h0,
                 Y, N, 32'hDEADBEEF, 32'hCAFEF00D, N, 32'hDEADBEEF, 32'hCAFEF00D, N};
    vecs[10] = '{Y, N, 4'h0, 10'h005, 32'h0, Y, Y, 4'h8, 10'h005, 32'h77000000,
                 Y, Y, 32'hDEADBEEF, 32'hDEADBEEF, N, 32'hDEADBEEF, 32'h77ADBEEF, N};
    vecs[11] = '{Y, N, 4'h0, 10'h005, 32'h0, Y, N, 4'h0, 10'h003, 32'h0,
                 Y, Y, 32'h77ADBEEF, 32'h00001003, N, 32'h77ADBEEF, 32'h00001003, N};
    vecs[12] = '{Y, Y, 4'hF, 10'h002, 32'h0A0A0A0A, Y, Y, 4'hF, 10'h002, 32'h0B0B0B0B,
                 Y, Y, 32'h00001002, 32'h00001002, Y, 32'h0A0A0A0A, 32'h0B0B0B0B, Y};
    vecs[13] = '{Y, Y, 4'h1, 10'h002, 32'h000000CC, Y, Y, 4'h1, 10'h002, 32'h000000DD,
                 Y, Y, 32'h0A0A0A0A, 32'h0A0A0A0A, Y, 32'h0B0B0BCC, 32'h0B0B0BDD, Y};
    vecs[14] = '{Y, N, 4'h0, 10'h002, 32'h0, N, N, 4'h0, 10'h000, 32'h0,
                 Y, N, 32'h0A0A0ACC, 32'h0A0A0A0A, N, 32'h0B0B0BDD, 32'h0B0B0BDD, N};

    rst = 1'b1;
    idle();
    step();
    step();
    for (int d = 0; d < 3; d++) chk_reset_state(d, $sformatf("reset dut%0d", d));
    rst = 1'b0;

    // Preload known contents on every instance.
    drive(Y, Y, 4'hF, 10'h000, 32'h00001000, Y, Y, 4'hF, 10'h001, 32'h00001001);
    step();
    drive(Y, Y, 4'hF, 10'h002, 32'h00001002, Y, Y, 4'hF, 10'h003, 32'h00001003);
    step();
    drive(Y, Y, 4'hF, 10'h005, 32'h00000000, Y, Y, 4'hF, 10'h010, 32'h11223344);
    step();
    drive(Y, Y, 4'hF, 10'h020, 32'h00000000, Y, Y, 4'hF, 10'h030, 32'h12345678);
    step();

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].en_a, vecs[i].we_a, vecs[i].be_a, vecs[i].addr_a, vecs[i].din_a,
            vecs[i].en_b, vecs[i].we_b, vecs[i].be_b, vecs[i].addr_b, vecs[i].din_b);
      step();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("v%0d dut%0d dvld_a", i, d), {31'h0, dvld_a[d]}, {31'h0, vecs[i].vld_a});
        chk($sformatf("v%0d dut%0d dvld_b", i, d), {31'h0, dvld_b[d]}, {31'h0, vecs[i].vld_b});
      end
      chk($sformatf("v%0d dut0 dout_a", i), dout_a[0], vecs[i].a0);
      chk($sformatf("v%0d dut0 dout_b", i), dout_b[0], vecs[i].b0);
      chk($sformatf("v%0d dut0 collide", i), {31'h0, collide[0]}, {31'h0, vecs[i].col0});
      chk($sformatf("v%0d dut1 dout_a", i), dout_a[1], vecs[i].a1);
      chk($sformatf("v%0d dut1 dout_b", i), dout_b[1], vecs[i].b1);
      chk($sformatf("v%0d dut1 collide", i), {31'h0, collide[1]}, {31'h0, vecs[i].col1});
    end

    // Pipelined instance: drain, then four back-to-back reads followed by idles.
    idle();
    step();
    step();
    begin
      logic [31:0] exp_d [8];
      logic        exp_v [8];
      exp_v = '{N, Y, Y, Y, Y, N, N, N};
      exp_d = '{32'h0, 32'h00001000, 32'h00001001, 32'h0A0A0ACC,
                32'h00001003, 32'h00001003, 32'h00001003, 32'h00001003};
      for (int e = 0; e < 8; e++) begin
        if (e < 4) drive(Y, N, 4'h0, e[9:0], 32'h0, N, N, 4'h0, 10'h000, 32'h0);
        else idle();
        step();
        chk($sformatf("pipe e%0d dvld_a", e), {31'h0, dvld_a[2]}, {31'h0, exp_v[e]});
        if (e > 0) chk($sformatf("pipe e%0d dout_a", e), dout_a[2], exp_d[e]);
      end
    end

    // Reset while two reads are in flight, with a colliding write in the reset cycle.
    drive(Y, N, 4'h0, 10'h000, 32'h0, N, N, 4'h0, 10'h000, 32'h0);
    step();
    drive(Y, N, 4'h0, 10'h001, 32'h0, N, N, 4'h0, 10'h000, 32'h0);
    step();
    rst = 1'b1;
    drive(Y, Y, 4'hF, 10'h003, 32'hFFFFFFFF, Y, Y, 4'hF, 10'h003, 32'h55555555);
    step();
    chk_reset_state(0, "midrst dut0");
    chk_reset_state(2, "midrst dut2");
    rst = 1'b0;
    idle();
    for (int e = 0; e < 2; e++) begin
      step();
      chk($sformatf("postrst e%0d dut2 dvld_a", e), {31'h0, dvld_a[2]}, 32'h0);
      chk($sformatf("postrst e%0d dut0 collide", e), {31'h0, collide[0]}, 32'h0);
    end
    drive(Y, N, 4'h0, 10'h003, 32'h0, N, N, 4'h0, 10'h000, 32'h0);
    step();
    chk("postrst read dut0 dvld_a", {31'h0, dvld_a[0]}, 32'h1);
    chk("postrst read dut0 dout_a", dout_a[0], 32'h00001003);
    chk("postrst read dut2 early dvld_a", {31'h0, dvld_a[2]}, 32'h0);
    idle();
    step();
    chk("postrst read dut2 dvld_a", {31'h0, dvld_a[2]}, 32'h1);
    chk("postrst read dut2 dout_a", dout_a[2], 32'h00001003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
